// File: rtl/mips_multicycle_processor.sv
// Multi-cycle MIPS core: one shared ALU sequenced by a five-state control FSM.
// Supports R-type add/sub/and/or/nor, addi, ori, lw, sw, beq, bne, j and memory-mapped I/O.
module mips_multicycle_processor #(
    parameter int                          MEMORY_DEPTH  = 32,
    parameter int                          DATA_DEPTH    = 64,
    parameter logic [MEMORY_DEPTH*32-1:0]  PROGRAM_IMAGE = '0,
    parameter logic [31:0]                 RESET_PC      = 32'h0040_0000,
    parameter logic [31:0]                 PORT_OUT_ADDR = 32'h1001_0024,
    parameter logic [31:0]                 PORT_IN_ADDR  = 32'h1001_0028
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  PortIn,
    output logic [31:0] ALUResultOut,
    output logic [31:0] PortOut,
    output logic        InstrDone
);

    localparam int ROM_AW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam int RAM_AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR
    } alu_op_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] aluout_q, aluout_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] port_q, port_d;
    logic [31:0] regs_q [32];
    logic [31:0] ram_q [DATA_DEPTH];

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] sext, zext;
    logic        is_r, is_j, is_beq, is_bne;
    logic        is_addi, is_ori, is_lw, is_sw, known;
    logic        unused_shamt;

    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign funct = ir_q[5:0];
    assign imm   = ir_q[15:0];
    assign sext  = {{16{imm[15]}}, imm};
    assign zext  = {16'h0000, imm};
    assign unused_shamt = ^ir_q[10:6];

    assign is_r    = (op == OP_R);
    assign is_j    = (op == OP_J);
    assign is_beq  = (op == OP_BEQ);
    assign is_bne  = (op == OP_BNE);
    assign is_addi = (op == OP_ADDI);
    assign is_ori  = (op == OP_ORI);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign known   = is_r | is_j | is_beq | is_bne |
                     is_addi | is_ori | is_lw | is_sw;

    // Program ROM: PC offset from RESET_PC, word-indexed, wrapping at depth
    logic [31:0]       pc_off;
    logic [ROM_AW-1:0] rom_idx;
    logic [31:0]       rom_word;

    assign pc_off   = pc_q - RESET_PC;
    assign rom_idx  = ROM_AW'((pc_off >> 2) % MEMORY_DEPTH);
    assign rom_word = PROGRAM_IMAGE[{rom_idx, 5'b00000} +: 32];

    logic [RAM_AW-1:0] ram_idx;
    assign ram_idx = aluout_q[RAM_AW+1:2];

    // ALU control for R-type function codes
    alu_op_e r_op;
    always_comb begin
        r_op = ALU_ADD;
        unique case (funct)
            6'h22:   r_op = ALU_SUB;
            6'h24:   r_op = ALU_AND;
            6'h25:   r_op = ALU_OR;
            6'h27:   r_op = ALU_NOR;
            default: r_op = ALU_ADD;
        endcase
    end

    logic [31:0] alu_a, alu_b, alu_y;
    alu_op_e     alu_op;
    logic        alu_zero;

    always_comb begin
        alu_y = '0;
        unique case (alu_op)
            ALU_ADD: alu_y = alu_a + alu_b;
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_NOR: alu_y = ~(alu_a | alu_b);
            default: alu_y = '0;
        endcase
    end
    assign alu_zero = (alu_y == 32'h0);

    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        ram_we;
    logic        done;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        aluout_d = aluout_q;
        mdr_d    = mdr_q;
        port_d   = port_q;
        alu_a    = a_q;
        alu_b    = b_q;
        alu_op   = ALU_ADD;
        rf_we    = 1'b0;
        rf_wa    = '0;
        rf_wd    = '0;
        ram_we   = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                alu_a   = pc_q;
                alu_b   = 32'd4;
                ir_d    = rom_word;
                pc_d    = alu_y;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d      = regs_q[rs];
                b_d      = regs_q[rt];
                alu_a    = pc_q;
                alu_b    = {sext[29:0], 2'b00};
                aluout_d = alu_y;
                if (is_j) begin
                    pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                    done    = 1'b1;
                    state_d = S_FETCH;
                end else if (!known) begin
                    done    = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (is_beq || is_bne) begin
                    alu_op = ALU_SUB;
                    if (is_beq == alu_zero) pc_d = aluout_q;
                    done    = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    alu_b = is_r ? b_q : (is_ori ? zext : sext);
                    alu_op = is_r ? r_op : (is_ori ? ALU_OR : ALU_ADD);
                    aluout_d = alu_y;
                    state_d  = (is_lw || is_sw) ? S_MEMORY : S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (is_sw) begin
                    if (aluout_q == PORT_OUT_ADDR) port_d = b_q;
                    else ram_we = 1'b1;
                    done    = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    mdr_d = (aluout_q == PORT_IN_ADDR) ?
                            {24'h0, PortIn} : ram_q[ram_idx];
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                rf_we   = 1'b1;
                rf_wa   = is_r ? rd : rt;
                rf_wd   = is_lw ? mdr_q : aluout_q;
                done    = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
            port_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
            port_q   <= port_d;
        end
    end

    // $0 is never written, so it reads zero forever after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (rf_we && rf_wa != 5'd0) begin
            regs_q[rf_wa] <= rf_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we && !reset) ram_q[ram_idx] <= b_q;
    end

    assign ALUResultOut = aluout_q;
    assign PortOut      = port_q;
    assign InstrDone    = done;

endmodule
